// File: rtl/digital_in_pkg.sv
// Shared definitions for the digital input peripheral: word register indices
// on the peripheral bus.
package digital_in_pkg;

  localparam logic [1:0] REG_STATE    = 2'd0;
  localparam logic [1:0] REG_FLAGS    = 2'd1;
  localparam logic [1:0] REG_IRQ_EN   = 2'd2;
  localparam logic [1:0] REG_EDGE_SEL = 2'd3;

endpackage

// File: rtl/din_debounce.sv
// One input bit: 2-FF synchronizer followed by a stability counter that only
// lets the filtered state follow the pin after DEB_CYCLES steady cycles.
module din_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic state,
  output logic change
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // change is high in the cycle whose closing posedge flips state
  assign change = (s2 != state) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= 1'b0;
      cnt   <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (s2 == state) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        state <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/digital_in.sv
// Memory-mapped digital input port: filtered pin state, sticky W1C edge flags,
// interrupt mask and edge polarity registers, and one level interrupt.
module digital_in
  import digital_in_pkg::*;
#(
  parameter int N_INPUTS   = 16,
  parameter int DEB_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_INPUTS-1:0] pins,
  input  logic [1:0]          A,
  input  logic [31:0]         WD,
  input  logic                WE,
  output logic [31:0]         RD,
  output logic                irq
);

  logic [N_INPUTS-1:0] state;
  logic [N_INPUTS-1:0] change;
  logic [N_INPUTS-1:0] evt;
  logic [N_INPUTS-1:0] flags;
  logic [N_INPUTS-1:0] irq_en;
  logic [N_INPUTS-1:0] edge_sel;
  logic [N_INPUTS-1:0] wd_bits;
  logic [N_INPUTS-1:0] flag_clr;
  logic [N_INPUTS-1:0] rd_bits;
  logic                unused_wd;

  for (genvar g = 0; g < N_INPUTS; g++) begin : g_pin
    din_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (pins[g]),
      .state (state[g]),
      .change(change[g])
    );
  end

  assign wd_bits   = WD[N_INPUTS-1:0];
  assign unused_wd = ^WD;

  // Rising: state about to go 0->1 with sel=0; falling: 1->0 with sel=1
  assign evt      = change & ~(edge_sel ^ state);
  assign flag_clr = (WE && (A == REG_FLAGS)) ? wd_bits : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags    <= '0;
      irq_en   <= '0;
      edge_sel <= '0;
    end else begin
      // New events are OR-ed after the clear so a colliding event survives
      flags <= (flags & ~flag_clr) | evt;
      if (WE && (A == REG_IRQ_EN))   irq_en   <= wd_bits;
      if (WE && (A == REG_EDGE_SEL)) edge_sel <= wd_bits;
    end
  end

  always_comb begin
    rd_bits = '0;
    case (A)
      REG_STATE:    rd_bits = state;
      REG_FLAGS:    rd_bits = flags;
      REG_IRQ_EN:   rd_bits = irq_en;
      REG_EDGE_SEL: rd_bits = edge_sel;
      default:      rd_bits = '0;
    endcase
  end

  assign RD  = 32'(rd_bits);
  assign irq = |(flags & irq_en);

endmodule

// File: tb/tb_digital_in.sv
// Directed bench for digital_in with N_INPUTS=16, DEB_CYCLES=4: register
// vector table plus hand-timed debounce, edge, W1C and reset sequences.
module tb_digital_in;

  localparam int N   = 16;
  localparam int DEB = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  pins;
  logic [1:0]    A;
  logic [31:0]   WD;
  logic          WE;
  logic [31:0]   RD;
  logic          irq;

  int n_checks;
  int n_errors;

  digital_in #(
    .N_INPUTS  (N),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .pins (pins),
    .A    (A),
    .WD   (WD),
    .WE   (WE),
    .RD   (RD),
    .irq  (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  a;
    logic        we;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver: called at a negedge, consumes one clock cycle
  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    A  = a;
    WD = d;
    WE = 1'b1;
    @(posedge clk);
    @(negedge clk);
    WE = 1'b0;
    WD = '0;
  endtask

  task automatic check_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    A = a;
    #1;
    check(name, RD, exp);
  endtask

  task automatic check_irq(input string name, input logic exp);
    #1;
    check(name, {31'd0, irq}, {31'd0, exp});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    pins  = '0;
    A     = '0;
    WD    = '0;
    WE    = 1'b0;

    vecs[0] = '{2'd0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[1] = '{2'd1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[2] = '{2'd2, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[3] = '{2'd3, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[4] = '{2'd2, 1'b1, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0};
    vecs[5] = '{2'd0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[6] = '{2'd3, 1'b1, 32'hABCD_1234, 32'h0000_1234, 1'b0};
    vecs[7] = '{2'd1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[8] = '{2'd3, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[9] = '{2'd2, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};

    wait_neg(2);
    check_irq("irq_in_reset", 1'b0);
    rst_n = 1'b1;
    wait_neg(1);

    // register vector table
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].we) write_reg(vecs[i].a, vecs[i].wd);
      check_rd($sformatf("vec%0d_rd", i), vecs[i].a, vecs[i].exp_rd);
      check_irq($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
    end

    // clean step on pin 3: state visible exactly 2+DEB posedges later
    write_reg(2'd2, 32'h0000_0008);
    pins[3] = 1'b1;
    wait_neg(5);
    check_rd("step_state_early", 2'd0, 32'h0);
    check_rd("step_flags_early", 2'd1, 32'h0);
    check_irq("step_irq_early", 1'b0);
    wait_neg(1);
    check_rd("step_state", 2'd0, 32'h0000_0008);
    check_rd("step_flags", 2'd1, 32'h0000_0008);
    check_irq("step_irq", 1'b1);
    write_reg(2'd1, 32'h0000_0008);
    check_rd("step_flags_clr", 2'd1, 32'h0);
    check_irq("step_irq_clr", 1'b0);

    // glitch rejection: 3-cycle pulse filtered, 4-cycle pulse accepted
    pins[0] = 1'b1;
    wait_neg(3);
    pins[0] = 1'b0;
    wait_neg(10);
    check_rd("glitch3_state", 2'd0, 32'h0000_0008);
    check_rd("glitch3_flags", 2'd1, 32'h0);
    pins[0] = 1'b1;
    wait_neg(4);
    pins[0] = 1'b0;
    wait_neg(4);
    check_rd("pulse4_state", 2'd0, 32'h0000_0009);
    check_rd("pulse4_flags", 2'd1, 32'h0000_0001);
    wait_neg(6);
    check_rd("pulse4_state_back", 2'd0, 32'h0000_0008);
    check_rd("pulse4_fall_noflag", 2'd1, 32'h0000_0001);
    write_reg(2'd1, 32'h0000_0001);

    // falling-edge selection on pin 0
    write_reg(2'd3, 32'h0000_0001);
    pins[0] = 1'b1;
    wait_neg(8);
    check_rd("fall_rise_state", 2'd0, 32'h0000_0009);
    check_rd("fall_rise_noflag", 2'd1, 32'h0);
    pins[0] = 1'b0;
    wait_neg(5);
    check_rd("fall_early_flags", 2'd1, 32'h0);
    wait_neg(1);
    check_rd("fall_state", 2'd0, 32'h0000_0008);
    check_rd("fall_flags", 2'd1, 32'h0000_0001);
    write_reg(2'd1, 32'h0000_0001);
    write_reg(2'd3, 32'h0000_0000);

    // W1C and mask: FLAGS=0x3, clear bit0 only
    pins[1:0] = 2'b11;
    wait_neg(8);
    check_rd("w1c_flags3", 2'd1, 32'h0000_0003);
    write_reg(2'd2, 32'h0000_0002);
    check_irq("w1c_irq_mask2", 1'b1);
    write_reg(2'd1, 32'h0000_0001);
    check_rd("w1c_flags2", 2'd1, 32'h0000_0002);
    check_irq("w1c_irq_after", 1'b1);
    write_reg(2'd2, 32'h0000_0001);
    check_irq("w1c_irq_masked", 1'b0);

    // collision: clear of bit1 sampled on the same posedge as a bit1 event
    write_reg(2'd3, 32'h0000_0002);
    pins[1] = 1'b0;
    wait_neg(5);
    check_rd("coll_pre_state", 2'd0, 32'h0000_000B);
    write_reg(2'd1, 32'h0000_0002);
    check_rd("coll_state", 2'd0, 32'h0000_0009);
    check_rd("coll_flags", 2'd1, 32'h0000_0002);
    write_reg(2'd1, 32'h0000_0002);
    check_rd("coll_flags_clr", 2'd1, 32'h0);

    // async reset mid-count on pin 2
    write_reg(2'd2, 32'h0000_0004);
    write_reg(2'd3, 32'h0000_0010);
    pins[2] = 1'b1;
    wait_neg(3);
    #2;
    rst_n = 1'b0;
    check_rd("arst_state", 2'd0, 32'h0);
    check_rd("arst_flags", 2'd1, 32'h0);
    check_rd("arst_irq_en", 2'd2, 32'h0);
    check_rd("arst_edge_sel", 2'd3, 32'h0);
    check_irq("arst_irq", 1'b0);
    wait_neg(1);
    rst_n = 1'b1;
    wait_neg(5);
    check_rd("arst_restart_early", 2'd0, 32'h0);
    wait_neg(1);
    check_rd("arst_restart_state", 2'd0, 32'h0000_000D);
    check_rd("arst_restart_flags", 2'd1, 32'h0000_000D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
